// File: rtl/booth_ctrl_pkg.sv
// Shared types for the arbitrated Booth multiplier: FSM state codes, Booth op decode, default sizes.
// Latency: n/a (definitions only); backpressure: n/a.
package booth_ctrl_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q_lsb, input logic q0);
        case ({q_lsb, q0})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_step.sv
// One radix-2 Booth iteration: add/sub of sign-extended M, then arithmetic shift of {A,q,q0}.
// Latency: combinational; backpressure: none (pure function).
module booth_step
    import booth_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic         q0,
    input  logic [N-1:0] m,
    output logic [N:0]   a_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q0_nxt
);

    logic [N:0] m_ext;
    logic [N:0] sum;

    assign m_ext = {m[N-1], m};

    always_comb begin
        sum = a;
        case (booth_decode(q[0], q0))
            OP_ADD:  sum = a + m_ext;
            OP_SUB:  sum = a - m_ext;
            default: sum = a;
        endcase
    end

    assign a_nxt  = {sum[N], sum[N:1]};
    assign q_nxt  = {sum[0], q[N-1:1]};
    assign q0_nxt = q[0];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbitrated sequential Booth multiplier returning a 2N-bit product tagged with requester id.
// Latency: handshake at t -> rsp_valid at t+N+1; holds response until rsp_ready, grants only in IDLE.
module booth_mul_arbiter
    import booth_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*N-1:0]   req_m,
    input  logic [NUM_REQ*N-1:0]   req_q,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*N-1:0]         rsp_product,
    output logic                   busy
);

    localparam int CNT_W = $clog2(N + 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_found;
    logic             hs;
    logic [N-1:0]     m_r;
    logic [N-1:0]     q_r;
    logic             q0_r;
    logic [N:0]       a_r;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     sel_m;
    logic [N-1:0]     sel_q;
    logic [N:0]       a_nxt;
    logic [N-1:0]     q_nxt;
    logic             q0_nxt;

    // Search starts just past the last winner so it gets lowest priority.
    always_comb begin : arbiter
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + 1 + k) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    assign hs = (state == ST_IDLE) && !rst && gnt_found;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_m = req_m[gnt_idx*N +: N];
    assign sel_q = req_q[gnt_idx*N +: N];
    assign busy  = (state != ST_IDLE);

    booth_step #(.N(N)) u_step (
        .a      (a_r),
        .q      (q_r),
        .q0     (q0_r),
        .m      (m_r),
        .a_nxt  (a_nxt),
        .q_nxt  (q_nxt),
        .q0_nxt (q0_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            id_r        <= '0;
            m_r         <= '0;
            q_r         <= '0;
            q0_r        <= 1'b0;
            a_r         <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        m_r    <= sel_m;
                        q_r    <= sel_q;
                        q0_r   <= 1'b0;
                        a_r    <= '0;
                        cnt    <= CNT_W'(N);
                        id_r   <= gnt_idx;
                        rr_ptr <= gnt_idx;
                        state  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    a_r  <= a_nxt;
                    q_r  <= q_nxt;
                    q0_r <= q0_nxt;
                    cnt  <= cnt - CNT_W'(1);
                    // Last step: publish the shifted result directly so DONE needs no extra cycle.
                    if (cnt == CNT_W'(1)) begin
                        state       <= ST_DONE;
                        rsp_valid   <= 1'b1;
                        rsp_product <= {a_nxt[N-1:0], q_nxt};
                        rsp_id      <= id_r;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed + randomized bench for booth_mul_arbiter with a spec-level arbitration/multiply model.
module tb_booth_mul_arbiter;

    localparam int N       = 4;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_m;
    logic [NUM_REQ*N-1:0] req_q;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [2*N-1:0]       rsp_product;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;
    int last_gnt;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_m       (req_m),
        .req_q       (req_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
        int p;
        p = $signed(m) * $signed(q);
        return p[2*N-1:0];
    endfunction

    function automatic int ref_grant(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_slot(input int i, input logic [N-1:0] m, input logic [N-1:0] q);
        req_m[i*N +: N] = m;
        req_q[i*N +: N] = q;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the response is consumed.
    task automatic transact(input logic [NUM_REQ-1:0] vmask, input bit keep, input int hold,
                            output logic [2*N-1:0] got, output logic [ID_W-1:0] got_id);
        int                 g;
        int                 lat;
        logic [2*N-1:0]     exp_p;
        logic [ID_W-1:0]    exp_id;
        logic [NUM_REQ-1:0] exp_rdy;
        req_valid = vmask;
        #1;
        g       = ref_grant(vmask, last_gnt);
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        chk("grant", req_ready, exp_rdy);
        chk("onehot", $onehot0(req_ready), 1);
        exp_p    = ref_mul(req_m[g*N +: N], req_q[g*N +: N]);
        exp_id   = g[ID_W-1:0];
        last_gnt = g;
        @(negedge clk);
        if (!keep) req_valid = '0;
        set_slot(g, N'($urandom), N'($urandom));
        chk("busy_iter", busy, 1);
        chk("rdy_iter", req_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 4*N) begin
            rsp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, N + 1);
        chk("product", rsp_product, exp_p);
        chk("rsp_id", rsp_id, exp_id);
        got    = rsp_product;
        got_id = rsp_id;
        for (int j = 0; j < hold; j++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_product", rsp_product, exp_p);
            chk("hold_id", rsp_id, exp_id);
            chk("hold_rdy", req_ready, 0);
            chk("hold_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("drop_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [2*N-1:0]     got;
        logic [ID_W-1:0]    got_id;
        logic [NUM_REQ-1:0] mask;
        logic [N-1:0]       sm;
        logic [N-1:0]       sq;
        int                 seen;

        rst       = 1'b1;
        req_valid = '1;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b0;
        last_gnt  = NUM_REQ - 1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // All requesters valid: fair rotation from reset, last job held under backpressure.
        set_slot(0, 4'h1, 4'h6);
        set_slot(1, 4'h3, 4'hA);
        set_slot(2, 4'h5, 4'h9);
        set_slot(3, 4'h7, 4'hC);
        for (int k = 0; k < 5; k++) begin
            transact('1, 1'b1, (k == 4) ? 10 : 0, got, got_id);
            chk("rr_order", got_id, k % NUM_REQ);
        end
        #1;
        chk("regrant", req_ready, 4'b0010);
        req_valid = '0;
        @(negedge clk);

        set_slot(0, 4'h3, 4'hE);
        transact(4'b0001, 1'b0, 0, got, got_id);
        chk("m3_qm2_product", got, 8'hFA);
        chk("m3_qm2_id", got_id, 0);

        set_slot(1, 4'h8, 4'h0);
        transact(4'b0010, 1'b0, 0, got, got_id);
        chk("m8_q0", got, 8'h00);
        set_slot(1, 4'h8, 4'h8);
        transact(4'b0010, 1'b0, 1, got, got_id);
        chk("m8_qm8", got, 8'h40);
        set_slot(1, 4'h8, 4'h7);
        transact(4'b0010, 1'b0, 0, got, got_id);
        chk("m8_q7", got, 8'hC8);

        // Reset mid-ITER on a job from requester 2 must abort silently.
        set_slot(2, 4'h5, 4'h3);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_product", rsp_product, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst      = 1'b0;
        last_gnt = NUM_REQ - 1;
        seen     = 0;
        for (int c = 0; c < 2*N; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("abort_no_rsp", seen, 0);
        set_slot(0, 4'h6, 4'hB);
        transact(4'b0001, 1'b0, 0, got, got_id);
        chk("post_abort_product", got, 8'hE2);
        chk("post_abort_id", got_id, 0);

        // Every (M,Q) pair through random requester sets with random backpressure.
        for (int p = 0; p < 256; p++) begin
            sm   = p[7:4];
            sq   = p[3:0];
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) set_slot(i, sm, sq);
            transact(mask, 1'b0, $urandom_range(0, 3), got, got_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
